// File: rtl/addsub_pkg.sv
// Shared op codes, FSM state encoding and flag bundle for the add/subtract sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package addsub_pkg;

    // Operation codes presented on the op input of addsub_seq.
    // op[1] selects the accumulator as operand A; op[0] selects subtraction.
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam logic [1:0] OP_ACC_ADD = 2'b10;
    localparam logic [1:0] OP_ACC_SUB = 2'b11;

    // Sequencer states: latch operands, let the adder settle, capture result.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_CAPT = 2'b10
    } state_t;

    // Status flags captured alongside the result.
    typedef struct packed {
        logic carry;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/addsub.sv
// Combinational add/subtract unit: result = dataa +/- datab, modulo 2^WIDTH.
// Latency: zero cycles (purely combinational).
// Backpressure: none; output follows inputs continuously.
module addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    input  logic             add_sub,
    output logic [WIDTH-1:0] result
);

    // add_sub = 1 adds, add_sub = 0 subtracts; wraps with no saturation.
    always_comb begin
        result = '0;
        if (add_sub) begin
            result = dataa + datab;
        end else begin
            result = dataa - datab;
        end
    end

endmodule

// File: rtl/addsub_seq.sv
// Add/subtract sequencer: latches a request, drives addsub, registers result, flags and accumulator.
// Latency: done pulses two cycles after the accepting edge; one request every three cycles.
// Backpressure: start is ignored while busy; no queueing, the caller must retry after done.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clear,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic [WIDTH-1:0] acc
);

    state_t             state_q;
    state_t             state_d;
    logic               load;
    logic               capt;

    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic               sub_q;

    logic [WIDTH-1:0]   sum;
    flags_t             flags_d;

    logic [WIDTH-1:0]   result_q;
    flags_t             flags_q;
    logic               done_q;
    logic [WIDTH-1:0]   acc_q;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the load/capture strobes for the datapath.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capt    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                capt    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand latch: acc is read before any same-cycle clear takes effect,
    // so a clear coinciding with an accept leaves this request untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa_q <= '0;
            opb_q <= '0;
            sub_q <= 1'b0;
        end else if (load) begin
            opa_q <= op[1] ? acc_q : a;
            opb_q <= b;
            sub_q <= op[0];
        end
    end

    addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .dataa   (opa_q),
        .datab   (opb_q),
        .add_sub (~sub_q),
        .result  (sum)
    );

    // Carry doubles as borrow on subtract; overflow is the signed-range check
    // expressed through operand and result sign bits.
    always_comb begin
        flags_d = '0;
        if (sub_q) begin
            flags_d.carry    = (opa_q < opb_q);
            flags_d.overflow = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) &&
                               (sum[WIDTH-1]   != opa_q[WIDTH-1]);
        end else begin
            flags_d.carry    = (sum < opa_q);
            flags_d.overflow = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                               (sum[WIDTH-1]   != opa_q[WIDTH-1]);
        end
    end

    // Result and flags are held from one completion to the next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (capt) begin
            result_q <= sum;
            flags_q  <= flags_d;
        end
    end

    // One-cycle completion pulse, coincident with the return to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= capt;
        end
    end

    // Accumulator: every completed op writes it, but a clear always wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (acc_clear) begin
            acc_q <= '0;
        end else if (capt) begin
            acc_q <= sum;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign carry    = flags_q.carry;
    assign overflow = flags_q.overflow;
    assign acc      = acc_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed plus randomized bench for addsub_seq against an integer-arithmetic reference model.
// Latency: checks done arrives exactly two cycles after accept and lasts one cycle.
// Backpressure: checks start is ignored while busy and that held start issues every third cycle.
module tb_addsub_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       acc_clear;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic [7:0] acc;

    int         n_checks;
    int         n_errors;
    logic [7:0] m_acc;

    addsub_seq #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc_clear (acc_clear),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic void model(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                                  input logic [7:0] accv, output logic [7:0] r,
                                  output logic c, output logic v);
        int x, y, s, sx, sy, ss;
        x  = o[1] ? int'(accv) : int'(av);
        y  = int'(bv);
        sx = (x > 127) ? x - 256 : x;
        sy = (y > 127) ? y - 256 : y;
        if (o[0]) begin
            s  = x - y;
            c  = (x < y);
            ss = sx - sy;
        end else begin
            s  = x + y;
            c  = (s > 255);
            ss = sx + sy;
        end
        v = (ss > 127) || (ss < -128);
        r = s[7:0];
    endfunction

    // Issue one request (optionally with acc_clear on the accepting edge) and check it completely.
    task automatic do_op(input logic [1:0] ov, input logic [7:0] av, input logic [7:0] bv,
                         input logic clr, input string tag);
        logic [7:0] er;
        logic       ec, ev;
        int         cyc;
        model(ov, av, bv, m_acc, er, ec, ev);
        @(negedge clk);
        start     = 1'b1;
        op        = ov;
        a         = av;
        b         = bv;
        acc_clear = clr;
        @(posedge clk);
        #1;
        start     = 1'b0;
        acc_clear = 1'b0;
        a         = 8'($urandom);
        b         = 8'($urandom);
        check({tag, ".busy_after_accept"}, busy, 1);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 6);
        check({tag, ".latency"}, cyc, 2);
        check({tag, ".result"}, result, er);
        check({tag, ".carry"}, carry, ec);
        check({tag, ".overflow"}, overflow, ev);
        check({tag, ".acc"}, acc, er);
        check({tag, ".busy_at_done"}, busy, 0);
        m_acc = er;
        @(posedge clk);
        #1;
        check({tag, ".done_one_cycle"}, done, 0);
    endtask

    initial begin
        int         ndone;
        logic [7:0] seen;
        logic [7:0] er;
        logic       ec, ev;

        n_checks  = 0;
        n_errors  = 0;
        m_acc     = 8'h00;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        a         = 8'h00;
        b         = 8'h00;
        acc_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.result", result, 0);
        check("reset.carry", carry, 0);
        check("reset.overflow", overflow, 0);
        check("reset.acc", acc, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed arithmetic cases, including the accumulate chain.
        do_op(2'b00, 8'd6,   8'd2,   1'b0, "add_6_2");
        do_op(2'b10, 8'h00,  8'hFA,  1'b0, "acc_add_FA");
        do_op(2'b11, 8'h00,  8'd3,   1'b0, "acc_sub_3");
        check("chain.acc_is_FF", acc, 8'hFF);
        do_op(2'b01, 8'd2,   8'd6,   1'b0, "sub_borrow");
        do_op(2'b01, 8'h80,  8'h01,  1'b0, "sub_ovf");
        do_op(2'b00, 8'h7F,  8'h01,  1'b0, "add_ovf");

        // Start pulsed again during EXEC with other operands must be ignored.
        model(2'b00, 8'd10, 8'd20, m_acc, er, ec, ev);
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 8'd10; b = 8'd20;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 8'h55; b = 8'h11;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        seen  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                seen = result;
            end
        end
        check("busy_ignore.done_count", ndone, 1);
        check("busy_ignore.result", seen, er);
        m_acc = er;

        // Reset asserted during EXEC aborts the operation.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 8'd1; b = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midreset.busy", busy, 0);
        check("midreset.result", result, 0);
        check("midreset.acc", acc, 0);
        check("midreset.done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midreset.no_done", ndone, 0);
        m_acc = 8'h00;

        // Reload the accumulator, then clear it during CAPT.
        do_op(2'b00, 8'h21, 8'h13, 1'b0, "reload");
        model(2'b10, 8'h00, 8'h05, m_acc, er, ec, ev);
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'h00; b = 8'h05;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        acc_clear = 1'b1;
        @(posedge clk);
        #1;
        check("capt_clear.done", done, 1);
        check("capt_clear.result", result, er);
        check("capt_clear.acc", acc, 0);
        @(negedge clk);
        acc_clear = 1'b0;
        m_acc = 8'h00;

        // Clear in IDLE on the accept edge: old acc used, result lands in acc.
        do_op(2'b00, 8'h40, 8'h02, 1'b0, "pre_clear");
        do_op(2'b10, 8'h00, 8'h01, 1'b1, "idle_clear");

        // Held start: one accept every three cycles.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 8'd3; b = 8'd4;
        ndone = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        start = 1'b0;
        check("held_start.done_count", ndone, 3);
        check("held_start.acc", acc, 8'd7);
        @(posedge clk);
        #1;
        check("held_start.idle_after", busy, 0);
        m_acc = 8'd7;

        // Randomized requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 7) == 0), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Sequencing controller for the processor's 8-bit add/subtract datapath. It accepts an operation request with a start/busy/done handshake and drives the operand and mode inputs of the `addsub` unit. It then registers the result together with carry/borrow and signed-overflow flags. An internal accumulator lets successive operations chain without the caller re-supplying the previous result.

## Interface
- `WIDTH`, 8, operand/result width in bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request strobe; accepted only while `busy`=0.
- `op`  in  2  operation code:
  - 00: A+B
  - 01: A−B
  - 10: ACC+B
  - 11: ACC−B
- `a`  in  WIDTH  operand A; sampled on accept.
- `b`  in  WIDTH  operand B; sampled on accept.
- `acc_clear`  in  1  synchronous clear of the accumulator.
- `busy`  out  1  high from the accept cycle until `done`.
- `done`  out  1  one-cycle pulse; `result` and flags are valid from this cycle.
- `result`  out  WIDTH  registered result; held until the next `done`.
- `carry`  out  1  add: unsigned carry-out; sub: borrow (A<B unsigned).
- `overflow`  out  1  two's-complement overflow.
- `acc`  out  WIDTH  current accumulator value.
- Clocking and reset (decided): one clock; reset is asynchronous and active-high.

## Operation
- FSM states: IDLE, EXEC, CAPT.
  - IDLE: when `start`=1, latch the operands:
    - `opa_q` = `op[1]` ? `acc` : `a`.
    - `opb_q` = `b`.
    - `sub_q` = `op[0]`.
    - Go to EXEC.
  - EXEC: drive `addsub` with dataa=`opa_q`, datab=`opb_q`, add_sub=~`sub_q` (1 = add). Go to CAPT.
  - CAPT: register `result`, `carry` and `overflow` from the settled `addsub` output, and write the accumulator with the result. Pulse `done` and go to IDLE.
- Flag rules (operands are the latched values; r = sum/difference):
  - add carry = r < opa (unsigned compare).
  - sub carry = opa < opb.
  - add overflow = (opa[W-1]==opb[W-1]) && (r[W-1]!=opa[W-1]).
  - sub overflow = (opa[W-1]!=opb[W-1]) && (r[W-1]!=opa[W-1]).
- All arithmetic is modulo 2^WIDTH; there is no saturation.
- The accumulator updates on every completed operation, including op 00 and 01.
- `start` while `busy`=1 is ignored; there is no queueing.
- `acc_clear` and an accumulator write in the same cycle: the clear wins, but `result` still shows the computed value.
- `acc_clear` while in IDLE does not affect an operation accepted that same cycle. ACC is sampled before the clear, so the old value is used.
- `a` and `b` changes after accept have no effect.

## Timing
- Accept at edge N (IDLE, `start`=1).
  - `busy`=1 after edge N.
  - `done`=1 after edge N+2 for exactly one cycle, then `busy`=0 in the same cycle.
- Issue rate: one request per 3 cycles. `start` may be held high in the `done` cycle, but it is accepted only at the next IDLE edge.
- Reset values:
  - State = IDLE.
  - `busy`, `done`, `carry`, `overflow` = 0.
  - `result`, `acc` = 0.
- Reset asserted mid-operation aborts immediately: no `done` pulse, accumulator = 0.

## Structure
- Shared package `addsub_pkg`:
  - Op-code localparams OP_ADD, OP_SUB, OP_ACC_ADD, OP_ACC_SUB.
  - State encodings S_IDLE, S_EXEC, S_CAPT.
- The one sub-module is the existing combinational `addsub` unit, instantiated with WIDTH=8. Flag logic stays local to `addsub_seq`.

## Test plan
- Add: reset, then start with op=00, a=6, b=2 → `done` 2 cycles after accept, result=8, carry=0, overflow=0, acc=8.
- Subtract with borrow and overflow cases:
  - op=01, a=2, b=6 → result=0xFC, carry=1, overflow=0.
  - op=01, a=0x80, b=0x01 → result=0x7F, overflow=1.
- Accumulate chain: after acc=8, op=10 with b=0xFA → result=0x02, carry=1. Then op=11 with b=3 → result=0xFF, carry=1, acc=0xFF.
- Signed add overflow: op=00, a=0x7F, b=0x01 → result=0x80, overflow=1, carry=0.
- Busy ignore: pulse `start` again during EXEC with different operands → exactly one `done`, and the result comes from the first request.
- Reset mid-op plus clear collision:
  - Assert `reset` in EXEC → no `done`; busy, result and acc = 0.
  - Separately, `acc_clear` during CAPT → acc=0, but result shows the computed value.
